// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared constants for the SHA-256 sigma sequencer: ALU
//               opcodes, function encodings, FSM state codes and the
//               per-function rotate/shift amount table.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

  // ALU opcodes understood by the shared combinational ALU
  localparam logic [4:0] ALU_OP_IDLE = 5'b00000;  // ADD, driven while idle
  localparam logic [4:0] ALU_OP_XOR  = 5'b01000;
  localparam logic [4:0] ALU_OP_ROTR = 5'b01001;
  localparam logic [4:0] ALU_OP_SHR  = 5'b01011;

  // func encodings
  localparam logic [1:0] FUNC_BSIG0 = 2'd0;  // capital sigma 0
  localparam logic [1:0] FUNC_BSIG1 = 2'd1;  // capital sigma 1
  localparam logic [1:0] FUNC_SSIG0 = 2'd2;  // small sigma 0
  localparam logic [1:0] FUNC_SSIG1 = 2'd3;  // small sigma 1

  // Shift amounts, indexed [func][term], in issue order
  localparam logic [3:0][2:0][4:0] SHIFT_TABLE = '{
    '{5'd10, 5'd19, 5'd17},   // func 3 : ROTR17, ROTR19, SHR10
    '{5'd3,  5'd18, 5'd7 },   // func 2 : ROTR7,  ROTR18, SHR3
    '{5'd25, 5'd11, 5'd6 },   // func 1 : ROTR6,  ROTR11, ROTR25
    '{5'd22, 5'd13, 5'd2 }    // func 0 : ROTR2,  ROTR13, ROTR22
  };

  // Bit f set when the last term of function f is a logical shift
  localparam logic [3:0] LAST_IS_SHR = 4'b1100;

  // FSM state codes
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TERM0 = 3'd1;
  localparam logic [2:0] ST_TERM1 = 3'd2;
  localparam logic [2:0] ST_MIX1  = 3'd3;
  localparam logic [2:0] ST_TERM2 = 3'd4;
  localparam logic [2:0] ST_MIX2  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sigma_term_rom.sv
`default_nettype none
// ============================================================================
// Module      : sigma_term_rom
// Description : Combinational lookup of (func, term index) to the ALU shift
//               amount and whether the term is a logical shift.
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_term_rom
  import sha_pkg::*;
(
  input  logic [1:0] func,
  input  logic [1:0] term,
  output logic [4:0] shiftamt,
  output logic       is_shr
);

  // Table lookup; term index 3 does not exist and yields zeros
  always_comb begin
    shiftamt = 5'd0;
    is_shr   = 1'b0;
    if (term != 2'd3) begin
      shiftamt = SHIFT_TABLE[func][term];
      is_shr   = (term == 2'd2) && LAST_IS_SHR[func];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha_sigma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sha_sigma_sequencer
// Description : Sequences three rotate/shift terms and two XOR merges through
//               a shared combinational ALU to compute one SHA-256 sigma
//               function of a 32-bit word. One result per 6 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_sigma_sequencer
  import sha_pkg::*;
#(
  parameter logic [4:0] OP_XOR  = ALU_OP_XOR,
  parameter logic [4:0] OP_ROTR = ALU_OP_ROTR,
  parameter logic [4:0] OP_SHR  = ALU_OP_SHR,
  parameter logic [4:0] OP_IDLE = ALU_OP_IDLE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  func,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result
);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] x_q;
  logic [1:0]  func_q;
  logic [31:0] acc;
  logic [31:0] tmp;
  logic [1:0]  term_idx;
  logic [4:0]  rom_shiftamt;
  logic        rom_is_shr;

  sigma_term_rom u_rom (
    .func     (func_q),
    .term     (term_idx),
    .shiftamt (rom_shiftamt),
    .is_shr   (rom_is_shr)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start only matters in IDLE and DONE
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:  state_next = start ? ST_TERM0 : ST_IDLE;
      ST_TERM0: state_next = ST_TERM1;
      ST_TERM1: state_next = ST_MIX1;
      ST_MIX1:  state_next = ST_TERM2;
      ST_TERM2: state_next = ST_MIX2;
      ST_MIX2:  state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_TERM0 : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode: status flags and ALU drive from the registered state
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    term_idx     = 2'd0;
    alu_opcode   = OP_IDLE;
    alu_operandA = 32'd0;
    alu_operandB = 32'd0;
    alu_shiftamt = 5'd0;
    case (state)
      ST_TERM0, ST_TERM1, ST_TERM2: begin
        busy         = 1'b1;
        term_idx     = (state == ST_TERM0) ? 2'd0 :
                       (state == ST_TERM1) ? 2'd1 : 2'd2;
        alu_opcode   = rom_is_shr ? OP_SHR : OP_ROTR;
        alu_operandA = x_q;
        alu_shiftamt = rom_shiftamt;
      end
      ST_MIX1, ST_MIX2: begin
        busy         = 1'b1;
        alu_opcode   = OP_XOR;
        alu_operandA = acc;
        alu_operandB = tmp;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: capture inputs on accept, accumulate ALU returns
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= 32'd0;
      func_q <= 2'd0;
      acc    <= 32'd0;
      tmp    <= 32'd0;
      result <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            x_q    <= x;
            func_q <= func;
          end
        end
        ST_TERM0:          acc <= alu_result;
        ST_TERM1, ST_TERM2: tmp <= alu_result;
        ST_MIX1:           acc <= alu_result;
        ST_MIX2: begin
          acc    <= alu_result;
          result <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sha_sigma_sequencer.md
# sha_sigma_sequencer

Multi-cycle sequencer that computes the four SHA-256 sigma functions (Σ0, Σ1, σ0, σ1) of a 32-bit word by issuing rotate, shift and XOR operations to the shared combinational ALU and accumulating the returned results. It sits directly in front of the ALU: it drives the opcode, operand and shift-amount inputs, and it consumes `data_result` in the same cycle. The round and message-schedule control logic starts it with a single-cycle handshake and reads one 32-bit result when `done` pulses.

## Interface
Parameters:
- `OP_XOR`, 5'b01000: ALU opcode for bitwise XOR.
- `OP_ROTR`, 5'b01001: ALU opcode for rotate right of operand A by `shiftamt`.
- `OP_SHR`, 5'b01011: ALU opcode for logical shift right of operand A by `shiftamt`.
- `OP_IDLE`, 5'b00000: opcode driven while idle (ADD).

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a computation; sampled only in IDLE or DONE.
- `func`  in  2: function select. 0=Σ0, 1=Σ1, 2=σ0, 3=σ1.
- `x`  in  32: input word; captured when `start` is accepted.
- `busy`  out  1: high while a computation is in progress (TERM0..MIX2).
- `done`  out  1: one-cycle pulse; `result` is valid on this cycle.
- `result`  out  32: final sigma value; held until the next accepted `start`.
- `alu_opcode`  out  5: to ALU `ctrl_ALUopcode`.
- `alu_operandA`  out  32: to ALU `data_operandA`.
- `alu_operandB`  out  32: to ALU `data_operandB`.
- `alu_shiftamt`  out  5: to ALU `ctrl_shiftamt`.
- `alu_result`  in  32: from ALU `data_result`; combinational with the outputs above.

## Operation
- Term table, in issue order:
  - Σ0 = ROTR2, ROTR13, ROTR22.
  - Σ1 = ROTR6, ROTR11, ROTR25.
  - σ0 = ROTR7, ROTR18, SHR3.
  - σ1 = ROTR17, ROTR19, SHR10.
- FSM states: IDLE, TERM0, TERM1, MIX1, TERM2, MIX2, DONE.
- IDLE or DONE with `start`=1: latch `x` into `x_q` and `func` into `func_q`, then go to TERM0. Otherwise IDLE holds and DONE returns to IDLE.
- TERMn: drive A=`x_q`, B=0, `shiftamt`=term n amount, opcode=ROTR (or SHR for σ term 2).
  - TERM0 writes `alu_result` into `acc`.
  - TERM1 and TERM2 write `alu_result` into `tmp`.
- MIXn: drive opcode=`OP_XOR`, A=`acc`, B=`tmp`, `shiftamt`=0; write `alu_result` into `acc`.
- State sequence: TERM0 → TERM1 → MIX1 → TERM2 → MIX2 → DONE.
  - On the MIX2 → DONE edge, `result` is loaded from the ALU XOR output.
- IDLE and DONE: drive `OP_IDLE` with all ALU operands 0.
- `start` during a busy state is ignored and not queued; `x` and `func` changes while busy have no effect.
- All arithmetic is 32-bit unsigned. The ALU overflow and compare outputs are unused.

## Timing
- Reset values: state=IDLE; `busy`=0; `done`=0; `result`=0; `acc`=`tmp`=0; `alu_opcode`=`OP_IDLE`; `alu_operandA`=`alu_operandB`=0; `alu_shiftamt`=0.
- All FSM outputs are decoded combinationally from the registered state and `x_q`/`func_q`/`acc`/`tmp`.
- Latency: `start` accepted on the edge ending cycle 0. Cycles 1–5 are busy (TERM0..MIX2). `done`=1 in cycle 6 with the new `result`.
- Back-to-back: `start` in the DONE cycle is accepted, so TERM0 follows directly. Throughput is one result per 6 cycles.
- Reset mid-operation: at the next edge the FSM returns to IDLE, `result` is cleared, and no `done` is produced.
- Reset has priority over `start` on the same edge.

## Structure
- Shared package `sha_pkg`: the ALU opcode constants, the `func` encodings, and the 4×3 shift-amount table with its per-function SHR flag for the last term.
- The FSM, registers and output decode live in one module.
- One natural sub-module: `sigma_term_rom`. It maps (`func`, term index) to (`shiftamt`, `is_shr`) and is purely combinational.
- The bench instantiates the real ALU connected to the `alu_*` ports.

## Test plan
- Σ0 (`func`=0), `x`=0x00000001 → `done` in cycle 6, `result`=0x40080400.
- Σ1 (`func`=1), `x`=0x00000001 → `result`=0x04200080.
- σ0 (`func`=2), `x`=0xFFFFFFFF → `result`=0x1FFFFFFF; σ0, `x`=0x00000001 → `result`=0x02004000.
- σ1 (`func`=3), `x`=1, with `start` held high and `x` changed to 0xDEADBEEF during cycles 1–5 → `result`=0x0000A000, then back-to-back start from DONE with no IDLE cycle.
- `reset` asserted in MIX1 → next cycle IDLE, `result`=0, `busy`=0, no `done` pulse; a following Σ0 of 1 completes normally.
- Check ALU port sequence for σ0 (`x`=1): opcodes 9, 9, 8, 11, 8 with shift amounts 7, 18, 0, 3, 0; `OP_IDLE` with zero operands in IDLE and DONE.
